// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the handshaked multicycle MIPS control FSM.
// Imported by the control top and its wait timer.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IF   = 4'd0,
        ST_ID   = 4'd1,
        ST_MAC  = 4'd2,
        ST_MAR  = 4'd3,
        ST_MAW  = 4'd4,
        ST_WB   = 4'd5,
        ST_EX   = 4'd6,
        ST_RC   = 4'd7,
        ST_EXI  = 4'd8,
        ST_RCI  = 4'd9,
        ST_BC   = 4'd10,
        ST_BNC  = 4'd11,
        ST_JC   = 4'd12,
        ST_JALC = 4'd13,
        ST_EXC  = 4'd14
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_BNE   = 3'b011;
    localparam logic [2:0] ALU_ADDI  = 3'b100;
    localparam logic [2:0] ALU_SLTI  = 3'b101;
    localparam logic [2:0] ALU_ANDI  = 3'b110;
    localparam logic [2:0] ALU_ORI   = 3'b111;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_EXC    = 2'b11;

    localparam logic [1:0] ALUB_B     = 2'b00;
    localparam logic [1:0] ALUB_FOUR  = 2'b01;
    localparam logic [1:0] ALUB_IMM   = 2'b10;
    localparam logic [1:0] ALUB_SHIMM = 2'b11;

    localparam logic [1:0] RD_RT  = 2'b00;
    localparam logic [1:0] RD_RD  = 2'b01;
    localparam logic [1:0] RD_R31 = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] CAUSE_RSVD    = 2'b00;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;

    // Immediate-group ALU opcode from the low opcode bits.
    function automatic logic [2:0] imm_aluop(input logic [2:0] op_lo);
        logic [2:0] r;
        case (op_lo)
            3'b000:  r = ALU_ADDI;
            3'b010:  r = ALU_SLTI;
            3'b100:  r = ALU_ANDI;
            3'b101:  r = ALU_ORI;
            default: r = ALU_ADD;
        endcase
        return r;
    endfunction

    function automatic logic is_mem_state(input state_e s);
        return (s == ST_IF) || (s == ST_MAR) || (s == ST_MAW);
    endfunction

endpackage

// File: rtl/mips_mem_wait_timer.sv
// Counts memory wait cycles; timeout flags the wait cycle that brings the
// count to MAX_WAIT while the access is still outstanding.
module mips_mem_wait_timer
    import mips_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic timeout
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] count_r;

    // Wait-cycle counter, saturating at MAX_WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (inc && (count_r != CW'(MAX_WAIT))) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign timeout = inc && (count_r == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/mips_control_hs.sv
// Multicycle MIPS control FSM with a req/ready memory handshake, bus timeout,
// JAL link write-back and a precise exception path.
module mips_control_hs
    import mips_ctrl_pkg::*;
#(
    parameter int MAX_WAIT   = 15,
    parameter bit ENABLE_JAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       memreq,
    output logic       memread,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       mdrwrite,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic [1:0] pcsource,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] aluop,
    output logic       regwrite,
    output logic [1:0] regdst,
    output logic [1:0] memtoreg,
    output logic       epcwrite,
    output logic       causewrite,
    output logic [1:0] cause
);

    state_e     state_r, state_next;
    logic [1:0] cause_r, cause_next;
    logic       wait_clr_s, wait_inc_s, timeout_s;

    // Any state change restarts the wait count, so each access starts from zero.
    assign wait_clr_s = (state_next != state_r);
    assign wait_inc_s = is_mem_state(state_r) && !mem_ready;

    mips_mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (wait_clr_s),
        .inc     (wait_inc_s),
        .timeout (timeout_s)
    );

    // State and exception cause registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IF;
            cause_r <= CAUSE_RSVD;
        end else begin
            state_r <= state_next;
            cause_r <= cause_next;
        end
    end

    // Next-state decode; cause only changes on the transition into EXC.
    always_comb begin
        state_next = state_r;
        cause_next = cause_r;
        case (state_r)
            ST_IF, ST_MAR, ST_MAW: begin
                if (mem_ready) begin
                    if (state_r == ST_IF) begin
                        state_next = ST_ID;
                    end else if (state_r == ST_MAR) begin
                        state_next = ST_WB;
                    end else begin
                        state_next = ST_IF;
                    end
                end else if (timeout_s) begin
                    state_next = ST_EXC;
                    cause_next = CAUSE_TIMEOUT;
                end else begin
                    state_next = state_r;
                end
            end
            ST_ID: begin
                case (op)
                    OP_RTYPE:        state_next = ST_EX;
                    OP_LW, OP_SW:    state_next = ST_MAC;
                    OP_BEQ:          state_next = ST_BC;
                    OP_BNE:          state_next = ST_BNC;
                    OP_J:            state_next = ST_JC;
                    OP_JAL: begin
                        if (ENABLE_JAL) begin
                            state_next = ST_JALC;
                        end else begin
                            state_next = ST_EXC;
                            cause_next = CAUSE_RSVD;
                        end
                    end
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_next = ST_EXI;
                    default: begin
                        state_next = ST_EXC;
                        cause_next = CAUSE_RSVD;
                    end
                endcase
            end
            ST_MAC: begin
                if (op[3]) begin
                    state_next = ST_MAW;
                end else begin
                    state_next = ST_MAR;
                end
            end
            ST_EX:   state_next = ST_RC;
            ST_EXI:  state_next = ST_RCI;
            default: state_next = ST_IF;
        endcase
    end

    // Moore output decode; only the handshake strobes look at mem_ready.
    always_comb begin
        memreq      = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        iord        = 1'b0;
        irwrite     = 1'b0;
        mdrwrite    = 1'b0;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        pcsource    = PCS_ALU;
        alusrca     = 1'b0;
        alusrcb     = ALUB_B;
        aluop       = ALU_ADD;
        regwrite    = 1'b0;
        regdst      = RD_RT;
        memtoreg    = M2R_ALUOUT;
        epcwrite    = 1'b0;
        causewrite  = 1'b0;
        cause       = CAUSE_RSVD;
        case (state_r)
            ST_IF: begin
                memreq  = 1'b1;
                memread = 1'b1;
                alusrcb = ALUB_FOUR;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            ST_ID: alusrcb = ALUB_SHIMM;
            ST_MAC: begin
                alusrca = 1'b1;
                alusrcb = ALUB_IMM;
            end
            ST_MAR: begin
                memreq   = 1'b1;
                memread  = 1'b1;
                iord     = 1'b1;
                mdrwrite = mem_ready;
            end
            ST_MAW: begin
                memreq   = 1'b1;
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            ST_WB: begin
                regwrite = 1'b1;
                memtoreg = M2R_MDR;
            end
            ST_EX, ST_RC: begin
                alusrca  = 1'b1;
                aluop    = ALU_FUNCT;
                regwrite = (state_r == ST_RC);
                regdst   = (state_r == ST_RC) ? RD_RD : RD_RT;
            end
            ST_EXI, ST_RCI: begin
                alusrca  = 1'b1;
                alusrcb  = ALUB_IMM;
                aluop    = imm_aluop(op[2:0]);
                regwrite = (state_r == ST_RCI);
            end
            ST_BC, ST_BNC: begin
                alusrca     = 1'b1;
                aluop       = (state_r == ST_BC) ? ALU_SUB : ALU_BNE;
                pcwritecond = 1'b1;
                pcsource    = PCS_ALUOUT;
            end
            ST_JC: begin
                pcwrite  = 1'b1;
                pcsource = PCS_JUMP;
            end
            ST_JALC: begin
                pcwrite  = 1'b1;
                pcsource = PCS_JUMP;
                regwrite = 1'b1;
                regdst   = RD_R31;
                memtoreg = M2R_PC;
            end
            ST_EXC: begin
                epcwrite   = 1'b1;
                causewrite = 1'b1;
                pcwrite    = 1'b1;
                pcsource   = PCS_EXC;
                cause      = cause_r;
            end
            default: begin
                memreq = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mips_control_hs.sv
// Directed bench for mips_control_hs: walks instruction sequences cycle by
// cycle and compares the full control word against hand-built expectations.
module tb_mips_control_hs;

    typedef struct packed {
        logic       memreq;
        logic       memread;
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       mdrwrite;
        logic       pcwrite;
        logic       pcwritecond;
        logic [1:0] pcsource;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] aluop;
        logic       regwrite;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic       epcwrite;
        logic       causewrite;
        logic [1:0] cause;
    } ctl_t;

    typedef enum int {
        T_IF, T_ID, T_MAC, T_MAR, T_MAW, T_WB, T_EX, T_RC,
        T_EXI, T_RCI, T_BC, T_BNC, T_JC, T_JALC, T_EXC
    } tst_e;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'b000000;
    logic       mem_ready = 1'b0;
    int         n_cmp = 0;
    int         n_mis = 0;

    logic       a_memreq, a_memread, a_memwrite, a_iord, a_irwrite, a_mdrwrite;
    logic       a_pcwrite, a_pcwritecond, a_alusrca, a_regwrite, a_epcwrite, a_causewrite;
    logic [1:0] a_pcsource, a_alusrcb, a_regdst, a_memtoreg, a_cause;
    logic [2:0] a_aluop;
    logic       b_memreq, b_memread, b_memwrite, b_iord, b_irwrite, b_mdrwrite;
    logic       b_pcwrite, b_pcwritecond, b_alusrca, b_regwrite, b_epcwrite, b_causewrite;
    logic [1:0] b_pcsource, b_alusrcb, b_regdst, b_memtoreg, b_cause;
    logic [2:0] b_aluop;
    ctl_t       a_obs, b_obs;

    always #5 clk = ~clk;

    mips_control_hs #(.MAX_WAIT(4), .ENABLE_JAL(1'b1)) u_dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .memreq(a_memreq), .memread(a_memread), .memwrite(a_memwrite), .iord(a_iord),
        .irwrite(a_irwrite), .mdrwrite(a_mdrwrite), .pcwrite(a_pcwrite),
        .pcwritecond(a_pcwritecond), .pcsource(a_pcsource), .alusrca(a_alusrca),
        .alusrcb(a_alusrcb), .aluop(a_aluop), .regwrite(a_regwrite), .regdst(a_regdst),
        .memtoreg(a_memtoreg), .epcwrite(a_epcwrite), .causewrite(a_causewrite),
        .cause(a_cause)
    );

    mips_control_hs #(.MAX_WAIT(15), .ENABLE_JAL(1'b0)) u_dut_nojal (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .memreq(b_memreq), .memread(b_memread), .memwrite(b_memwrite), .iord(b_iord),
        .irwrite(b_irwrite), .mdrwrite(b_mdrwrite), .pcwrite(b_pcwrite),
        .pcwritecond(b_pcwritecond), .pcsource(b_pcsource), .alusrca(b_alusrca),
        .alusrcb(b_alusrcb), .aluop(b_aluop), .regwrite(b_regwrite), .regdst(b_regdst),
        .memtoreg(b_memtoreg), .epcwrite(b_epcwrite), .causewrite(b_causewrite),
        .cause(b_cause)
    );

    assign a_obs = {a_memreq, a_memread, a_memwrite, a_iord, a_irwrite, a_mdrwrite,
                    a_pcwrite, a_pcwritecond, a_pcsource, a_alusrca, a_alusrcb, a_aluop,
                    a_regwrite, a_regdst, a_memtoreg, a_epcwrite, a_causewrite, a_cause};
    assign b_obs = {b_memreq, b_memread, b_memwrite, b_iord, b_irwrite, b_mdrwrite,
                    b_pcwrite, b_pcwritecond, b_pcsource, b_alusrca, b_alusrcb, b_aluop,
                    b_regwrite, b_regdst, b_memtoreg, b_epcwrite, b_causewrite, b_cause};

    // Expected control word for a state, written straight from the state table.
    function automatic ctl_t expect_ctl(input tst_e st, input logic rdy,
                                        input logic [1:0] cs, input logic [2:0] iaop);
        ctl_t c;
        c = '0;
        case (st)
            T_IF: begin
                c.memreq = 1'b1; c.memread = 1'b1; c.alusrcb = 2'b01;
                c.irwrite = rdy; c.pcwrite = rdy;
            end
            T_ID:  c.alusrcb = 2'b11;
            T_MAC: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            T_MAR: begin
                c.memreq = 1'b1; c.memread = 1'b1; c.iord = 1'b1; c.mdrwrite = rdy;
            end
            T_MAW: begin c.memreq = 1'b1; c.memwrite = 1'b1; c.iord = 1'b1; end
            T_WB:  begin c.regwrite = 1'b1; c.memtoreg = 2'b01; end
            T_EX:  begin c.alusrca = 1'b1; c.aluop = 3'b010; end
            T_RC:  begin
                c.alusrca = 1'b1; c.aluop = 3'b010; c.regwrite = 1'b1; c.regdst = 2'b01;
            end
            T_EXI: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluop = iaop; end
            T_RCI: begin
                c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluop = iaop; c.regwrite = 1'b1;
            end
            T_BC:  begin
                c.alusrca = 1'b1; c.aluop = 3'b001; c.pcwritecond = 1'b1; c.pcsource = 2'b01;
            end
            T_BNC: begin
                c.alusrca = 1'b1; c.aluop = 3'b011; c.pcwritecond = 1'b1; c.pcsource = 2'b01;
            end
            T_JC:  begin c.pcwrite = 1'b1; c.pcsource = 2'b10; end
            T_JALC: begin
                c.pcwrite = 1'b1; c.pcsource = 2'b10; c.regwrite = 1'b1;
                c.regdst = 2'b10; c.memtoreg = 2'b10;
            end
            T_EXC: begin
                c.epcwrite = 1'b1; c.causewrite = 1'b1; c.pcwrite = 1'b1;
                c.pcsource = 2'b11; c.cause = cs;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %07h expected %07h", tag, obs, exp);
        end
    endtask

    // One clock: drive mem_ready, compare at the falling edge, advance past the rising edge.
    task automatic cyc(input string tag, input tst_e st, input logic rdy,
                       input logic [1:0] cs, input logic [2:0] iaop);
        mem_ready = rdy;
        @(negedge clk);
        check(tag, 32'(a_obs), 32'(expect_ctl(st, rdy, cs, iaop)));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        @(posedge clk);
        #1;
        do_reset();
        cyc("reset_if", T_IF, 1'b0, 2'b00, 3'b000);

        // R-type, zero-wait memory: IF ID EX RC, back in IF on cycle 5
        do_reset();
        op = 6'b000000;
        cyc("r_if", T_IF, 1'b1, 2'b00, 3'b000);
        cyc("r_id", T_ID, 1'b1, 2'b00, 3'b000);
        cyc("r_ex", T_EX, 1'b1, 2'b00, 3'b000);
        cyc("r_rc", T_RC, 1'b1, 2'b00, 3'b000);
        cyc("r_if5", T_IF, 1'b0, 2'b00, 3'b000);

        // LW with 3 wait cycles in IF and in MAR: 11 cycles
        do_reset();
        op = 6'b100011;
        for (int i = 0; i < 3; i++) cyc("lw_if_wait", T_IF, 1'b0, 2'b00, 3'b000);
        cyc("lw_if_rdy", T_IF, 1'b1, 2'b00, 3'b000);
        cyc("lw_id", T_ID, 1'b0, 2'b00, 3'b000);
        cyc("lw_mac", T_MAC, 1'b0, 2'b00, 3'b000);
        for (int i = 0; i < 3; i++) cyc("lw_mar_wait", T_MAR, 1'b0, 2'b00, 3'b000);
        cyc("lw_mar_rdy", T_MAR, 1'b1, 2'b00, 3'b000);
        cyc("lw_wb", T_WB, 1'b0, 2'b00, 3'b000);
        cyc("lw_next_if", T_IF, 1'b0, 2'b00, 3'b000);

        // Reserved opcode
        do_reset();
        op = 6'b111111;
        cyc("rsv_if", T_IF, 1'b1, 2'b00, 3'b000);
        cyc("rsv_id", T_ID, 1'b0, 2'b00, 3'b000);
        cyc("rsv_exc", T_EXC, 1'b0, 2'b00, 3'b000);
        cyc("rsv_if2", T_IF, 1'b0, 2'b00, 3'b000);

        // SW timeout (MAX_WAIT=4): four wait cycles in MAW, then EXC cause 01
        do_reset();
        op = 6'b101011;
        cyc("swto_if", T_IF, 1'b1, 2'b00, 3'b000);
        cyc("swto_id", T_ID, 1'b0, 2'b00, 3'b000);
        cyc("swto_mac", T_MAC, 1'b0, 2'b00, 3'b000);
        for (int i = 0; i < 4; i++) cyc("swto_maw", T_MAW, 1'b0, 2'b00, 3'b000);
        cyc("swto_exc", T_EXC, 1'b0, 2'b01, 3'b000);
        cyc("swto_if2", T_IF, 1'b0, 2'b00, 3'b000);

        // SW with ready on the cycle the count reaches MAX_WAIT: ready wins
        do_reset();
        op = 6'b101011;
        cyc("swok_if", T_IF, 1'b1, 2'b00, 3'b000);
        cyc("swok_id", T_ID, 1'b0, 2'b00, 3'b000);
        cyc("swok_mac", T_MAC, 1'b0, 2'b00, 3'b000);
        for (int i = 0; i < 3; i++) cyc("swok_maw_wait", T_MAW, 1'b0, 2'b00, 3'b000);
        cyc("swok_maw_rdy", T_MAW, 1'b1, 2'b00, 3'b000);
        cyc("swok_if2", T_IF, 1'b0, 2'b00, 3'b000);

        // Fetch timeout
        do_reset();
        for (int i = 0; i < 4; i++) cyc("ifto_wait", T_IF, 1'b0, 2'b00, 3'b000);
        cyc("ifto_exc", T_EXC, 1'b0, 2'b01, 3'b000);

        // JAL: enabled instance links, disabled instance traps with cause 00
        do_reset();
        op = 6'b000011;
        cyc("jal_if", T_IF, 1'b1, 2'b00, 3'b000);
        cyc("jal_id", T_ID, 1'b0, 2'b00, 3'b000);
        #2;
        check("nojal_exc", 32'(b_obs), 32'(expect_ctl(T_EXC, 1'b0, 2'b00, 3'b000)));
        cyc("jal_jalc", T_JALC, 1'b0, 2'b00, 3'b000);
        cyc("jal_if2", T_IF, 1'b0, 2'b00, 3'b000);

        // Immediate ops: ORI and SLTI aluop decode
        do_reset();
        op = 6'b001101;
        cyc("ori_if", T_IF, 1'b1, 2'b00, 3'b000);
        cyc("ori_id", T_ID, 1'b0, 2'b00, 3'b000);
        cyc("ori_exi", T_EXI, 1'b0, 2'b00, 3'b111);
        cyc("ori_rci", T_RCI, 1'b0, 2'b00, 3'b111);
        op = 6'b001010;
        cyc("slti_if", T_IF, 1'b1, 2'b00, 3'b000);
        cyc("slti_id", T_ID, 1'b0, 2'b00, 3'b000);
        cyc("slti_exi", T_EXI, 1'b0, 2'b00, 3'b101);
        cyc("slti_rci", T_RCI, 1'b0, 2'b00, 3'b101);

        // Branches and jump
        op = 6'b000100;
        cyc("beq_if", T_IF, 1'b1, 2'b00, 3'b000);
        cyc("beq_id", T_ID, 1'b0, 2'b00, 3'b000);
        cyc("beq_bc", T_BC, 1'b0, 2'b00, 3'b000);
        op = 6'b000101;
        cyc("bne_if", T_IF, 1'b1, 2'b00, 3'b000);
        cyc("bne_id", T_ID, 1'b0, 2'b00, 3'b000);
        cyc("bne_bnc", T_BNC, 1'b0, 2'b00, 3'b000);
        op = 6'b000010;
        cyc("j_if", T_IF, 1'b1, 2'b00, 3'b000);
        cyc("j_id", T_ID, 1'b0, 2'b00, 3'b000);
        cyc("j_jc", T_JC, 1'b0, 2'b00, 3'b000);
        cyc("j_if2", T_IF, 1'b0, 2'b00, 3'b000);

        // Reset on the 2nd MAR wait cycle, after a timeout has loaded cause 01
        do_reset();
        for (int i = 0; i < 4; i++) cyc("pre_to_wait", T_IF, 1'b0, 2'b00, 3'b000);
        cyc("pre_to_exc", T_EXC, 1'b0, 2'b01, 3'b000);
        op = 6'b100011;
        cyc("rmar_if", T_IF, 1'b1, 2'b00, 3'b000);
        cyc("rmar_id", T_ID, 1'b0, 2'b00, 3'b000);
        cyc("rmar_mac", T_MAC, 1'b0, 2'b00, 3'b000);
        cyc("rmar_w1", T_MAR, 1'b0, 2'b00, 3'b000);
        reset = 1'b1;
        cyc("rmar_w2", T_MAR, 1'b0, 2'b00, 3'b000);
        reset = 1'b0;
        cyc("rmar_if_after", T_IF, 1'b0, 2'b00, 3'b000);
        // A timeout that never reaches EXC must not disturb the cleared cause:
        // a reserved opcode now must report cause 00.
        op = 6'b111111;
        cyc("rmar_rsv_if", T_IF, 1'b1, 2'b00, 3'b000);
        cyc("rmar_rsv_id", T_ID, 1'b0, 2'b00, 3'b000);
        cyc("rmar_rsv_exc", T_EXC, 1'b0, 2'b00, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/mips_control_hs.md
# mips_control_hs

Multicycle MIPS control FSM with a memory handshake. Sits between the instruction register opcode field and the multicycle datapath, driving mux selects, write enables and the ALU-control opcode. It adds variable-latency memory (req/ready with timeout), JAL link write-back, and a precise exception path (EPC/Cause write, jump to vector) for reserved opcodes and bus timeouts.

## Interface
- MAX_WAIT, 15: maximum cycles a memory access may wait for `mem_ready` before a bus-timeout exception; legal range 1..255.
- ENABLE_JAL, 1: when 1, opcode 000011 executes JAL; when 0 it raises a reserved-opcode exception.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; state returns to IF.
- op  input  6  opcode from the instruction register.
- mem_ready  input  1  memory completes the current access this cycle.
- memreq  output  1  memory access in progress; held until `mem_ready` or timeout.
- memread, memwrite  output  1  access direction, valid while `memreq`=1.
- iord  output  1  address select: 0 = PC, 1 = ALUOut.
- irwrite, mdrwrite  output  1  load the instruction register / memory data register.
- pcwrite, pcwritecond  output  1  unconditional / branch-qualified PC write.
- pcsource  output  2  00 ALU, 01 ALUOut, 10 jump target, 11 exception vector.
- alusrca  output  1  0 = PC, 1 = register A.
- alusrcb  output  2  00 B, 01 constant 4, 10 sign-extended immediate, 11 shifted immediate.
- aluop  output  3  000 add, 001 sub/beq, 010 funct, 011 bne, 100 addi, 101 slti, 110 andi, 111 ori.
- regwrite  output  1  register file write enable.
- regdst  output  2  00 rt, 01 rd, 10 register 31.
- memtoreg  output  2  00 ALUOut, 01 MDR, 10 PC.
- epcwrite, causewrite  output  1  load EPC / Cause.
- cause  output  2  00 reserved opcode, 01 bus timeout; valid with `causewrite`.

## Operation
- States: IF, ID, MAC, MAR, MAW, WB, EX, RC, EXI, RCI, BC, BNC, JC, JALC, EXC.
- IF:
  - memreq=memread=1, iord=0, alusrca=0, alusrcb=01, aluop=000.
  - Holds until `mem_ready`. On the ready cycle, irwrite=pcwrite=1 (pcsource=00) and the next state is ID.
- ID: alusrcb=11, aluop=000. Next state by op:
  - 000000 → EX.
  - 100011 or 101011 → MAC.
  - 000100 → BC.
  - 000101 → BNC.
  - 000010 → JC.
  - 000011 → JALC if ENABLE_JAL=1, else EXC.
  - 001000, 001010, 001100, 001101 → EXI.
  - Any other opcode → EXC with cause 00.
- MAC: alusrca=1, alusrcb=10, aluop=000. Next state is MAW if op[3]=1, else MAR.
- MAR: memreq=memread=1, iord=1. Waits for `mem_ready`; mdrwrite=1 on the ready cycle; next state WB.
- MAW: memreq=memwrite=1, iord=1. Waits for `mem_ready`; next state IF.
- WB: regwrite=1, regdst=00, memtoreg=01; next state IF.
- EX: alusrca=1, alusrcb=00, aluop=010; next state RC.
- RC: same ALU controls as EX, plus regwrite=1, regdst=01; next state IF.
- EXI: alusrca=1, alusrcb=10, aluop decoded from op[2:0]: 000→100, 010→101, 100→110, 101→111. Next state RCI.
- RCI: same ALU controls as EXI, plus regwrite=1, regdst=00, memtoreg=00; next state IF.
- BC: alusrca=1, alusrcb=00, aluop=001, pcwritecond=1, pcsource=01; next state IF.
- BNC: same as BC except aluop=011.
- JC: pcwrite=1, pcsource=10; next state IF.
- JALC: pcwrite=1, pcsource=10, regwrite=1, regdst=10, memtoreg=10; next state IF.
- EXC: epcwrite=causewrite=1, pcwrite=1, pcsource=11. Cause is held in an internal register set on entry. Next state IF.
- Every output not listed for a state is 0.

## Timing
- All outputs are Moore functions of state, except irwrite/pcwrite in IF and mdrwrite in MAR, which are additionally qualified by `mem_ready`.
- Zero-wait memory, cycles per instruction:
  - 3: jump, branch, JAL.
  - 4: R-type, immediate ops, SW.
  - 5: LW.
- Each wait cycle adds 1 cycle.
- Wait counter:
  - Clears on entry to IF, MAR or MAW.
  - Increments on each cycle in those states with `mem_ready`=0.
  - Timeout fires when it reaches MAX_WAIT with `mem_ready` still 0: next state EXC, cause 01.
  - If `mem_ready`=1 on the same cycle the counter reaches MAX_WAIT, ready wins and no exception is raised.
- `mem_ready` outside IF, MAR and MAW is ignored.
- Reset:
  - Effective on the edge; overrides any pending wait or exception.
  - Clears the counter and the cause register.
  - After reset the FSM is in IF, so the outputs are memreq=memread=1, alusrcb=01, all others 0.

## Structure
- Package `mips_ctrl_pkg` holds:
  - the state enum (4 bits);
  - the opcode constants;
  - the aluop, pcsource, regdst, memtoreg and cause encodings.
- Sub-module `mips_mem_wait_timer` provides the clear/increment counter and `timeout` flag; its width is $clog2(MAX_WAIT+1).

## Test plan
- Reset, then op=000000 with `mem_ready` tied to 1 → IF, ID, EX, RC; regwrite=1 with regdst=01 in RC; back in IF on cycle 5.
- LW (100011) with a 3-cycle ready delay in both IF and MAR → memreq held 3 cycles each time; mdrwrite pulses once; WB gives regwrite=1, memtoreg=01; 11 cycles total.
- op=111111 → EXC after ID, with causewrite=1, cause=00, pcsource=11, epcwrite=1.
- MAX_WAIT=4 with `mem_ready` held at 0 in MAW → EXC with cause=01 after 4 wait cycles; memwrite deasserts in EXC.
- JAL with ENABLE_JAL=1 → JALC: regdst=10, memtoreg=10, pcsource=10. With ENABLE_JAL=0 → EXC with cause=00.
- Assert reset during the 2nd wait cycle of MAR → next cycle in IF with memreq=1 and cause register cleared.
